// File: rtl/axi4_lite_line_master.sv
`default_nettype none
// ============================================================================
// Module  : axi4_lite_line_master
// Brief   : Moves one cache line between the cache and an AXI4-Lite slave,
//           one word transaction at a time (line fill or line writeback).
//           Optional macro AXI_RESP_CHECK_EN enables the sticky o_axi_err flag.
// Rev     : 1.0  initial release
// ============================================================================
module axi4_lite_line_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                          i_clk,
    input  logic                          i_arstn,

    input  logic                          i_read_start,
    input  logic                          i_write_start,
    input  logic [ADDR_W-1:0]             i_line_addr,
    output logic [$clog2(LINE_WORDS)-1:0] o_word_idx,
    input  logic [DATA_W-1:0]             i_wr_word,
    output logic [DATA_W-1:0]             o_rd_word,
    output logic                          o_rd_word_we,
    output logic                          o_axi_done,
    output logic                          o_axi_err,

    output logic [ADDR_W-1:0]             o_awaddr,
    output logic [2:0]                    o_awprot,
    output logic                          o_awvalid,
    input  logic                          i_awready,

    output logic [DATA_W-1:0]             o_wdata,
    output logic [DATA_W/8-1:0]           o_wstrb,
    output logic                          o_wvalid,
    input  logic                          i_wready,

    input  logic [1:0]                    i_bresp,
    input  logic                          i_bvalid,
    output logic                          o_bready,

    output logic [ADDR_W-1:0]             o_araddr,
    output logic [2:0]                    o_arprot,
    output logic                          o_arvalid,
    input  logic                          i_arready,

    input  logic [DATA_W-1:0]             i_rdata,
    input  logic [1:0]                    i_rresp,
    input  logic                          i_rvalid,
    output logic                          o_rready
);

    localparam int c_IDX_W  = $clog2(LINE_WORDS);
    localparam int c_BYTE_W = $clog2(DATA_W / 8);
    localparam int c_OFF_W  = c_IDX_W + c_BYTE_W;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0]   r_base;
    logic                r_aw_pend;
    logic                r_w_pend;

    logic                w_latch;
    logic                w_idx_inc;
    logic                w_wr_enter;
    logic                w_last;
    logic [ADDR_W-1:0]   w_word_addr;

    assign w_last      = (r_idx == c_LAST_IDX);
    assign w_word_addr = r_base + (ADDR_W'(r_idx) << c_BYTE_W);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and channel control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_idx_inc    = 1'b0;
        w_wr_enter   = 1'b0;
        o_arvalid    = 1'b0;
        o_rready     = 1'b0;
        o_bready     = 1'b0;
        o_rd_word_we = 1'b0;
        o_axi_done   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_write_start) begin
                    w_latch     = 1'b1;
                    w_wr_enter  = 1'b1;
                    w_state_nxt = ST_WR_REQ;
                end else if (i_read_start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_RD_ADDR;
                end
            end

            ST_RD_ADDR: begin
                o_arvalid = 1'b1;
                if (i_arready) begin
                    w_state_nxt = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                o_rready = 1'b1;
                if (i_rvalid) begin
                    o_rd_word_we = 1'b1;
                    w_idx_inc    = 1'b1;
                    w_state_nxt  = w_last ? ST_DONE : ST_RD_ADDR;
                end
            end

            ST_WR_REQ: begin
                // A channel counts as complete if it already handshook or does so now.
                if ((!r_aw_pend || i_awready) && (!r_w_pend || i_wready)) begin
                    w_state_nxt = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                o_bready = 1'b1;
                if (i_bvalid) begin
                    w_idx_inc = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_wr_enter  = 1'b1;
                        w_state_nxt = ST_WR_REQ;
                    end
                end
            end

            ST_DONE: begin
                o_axi_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line base and word counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_base <= '0;
            r_idx  <= '0;
        end else if (w_latch) begin
            r_base <= {i_line_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
            r_idx  <= '0;
        end else if (w_idx_inc) begin
            // Wraps to 0 after the last word since LINE_WORDS is a power of two.
            r_idx <= r_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Independent AW / W valid tracking inside WR_REQ
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
        end else if (w_wr_enter) begin
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
        end else if (r_state == ST_WR_REQ) begin
            if (i_awready) begin
                r_aw_pend <= 1'b0;
            end
            if (i_wready) begin
                r_w_pend <= 1'b0;
            end
        end
    end

    assign o_awvalid  = (r_state == ST_WR_REQ) && r_aw_pend;
    assign o_wvalid   = (r_state == ST_WR_REQ) && r_w_pend;
    assign o_awaddr   = w_word_addr;
    assign o_araddr   = w_word_addr;
    assign o_awprot   = 3'b000;
    assign o_arprot   = 3'b000;
    assign o_wdata    = i_wr_word;
    assign o_wstrb    = '1;
    assign o_rd_word  = i_rdata;
    assign o_word_idx = r_idx;

    logic w_unused_addr;
    assign w_unused_addr = ^i_line_addr[c_OFF_W-1:0];

    // ------------------------------------------------------------------
    // Response error flag
    // ------------------------------------------------------------------
`ifdef AXI_RESP_CHECK_EN
    logic r_err;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_err <= 1'b0;
        end else if ((o_rready && i_rvalid && (i_rresp != 2'b00)) ||
                     (o_bready && i_bvalid && (i_bresp != 2'b00))) begin
            r_err <= 1'b1;
        end
    end

    assign o_axi_err = r_err;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{i_rresp, i_bresp};
    assign o_axi_err     = 1'b0;
`endif

endmodule
`default_nettype wire
